// File: rtl/mm_sequencer_if.sv
// Shared dmem port between the matrix-multiply sequencer and data memory.
// The sequencer owns request/address/direction; memory returns ack and the
// low word of the returned beat.
interface mm_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mm_sequencer.sv
// mm_sequencer: self-timed master FSM for the matrix-multiply accelerator.
// Fetches the packed m/n/o dimension word, then walks the i/j/k loops issuing
// A-word loads, B-beat loads, MAC strobes and C-beat stores on one dmem port.
// C is produced in LANES-wide row blocks: C[i][j..j+LANES-1].
// Optional feature: define MM_PERF_CNT_EN to build the busy-cycle counter
// that drives perf_cycles; otherwise perf_cycles is tied to zero.
module mm_sequencer #(
    parameter logic [31:0] A_BASE   = 32'h0000_0000,
    parameter logic [31:0] B_BASE   = 32'h0000_1400,
    parameter logic [31:0] C_BASE   = 32'h0000_2800,
    parameter logic [31:0] DIM_ADDR = 32'h0000_3C00,
    parameter int          LANES    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    mm_sequencer_if.master    mem,
    output logic              a_ld,
    output logic              b_ld,
    output logic              mac_en,
    output logic              acc_clr,
    output logic [LANES-1:0]  lane_mask,
    output logic              busy,
    output logic              done,
    output logic              dim_err,
    output logic [31:0]       perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_DIM, S_CHK, S_LD_A, S_LD_B, S_MAC, S_ST_C, S_FIN
    } state_t;

    localparam logic [31:0] LANES_W = LANES;

    state_t      state_q, state_d;
    logic [10:0] m_q, m_d;
    logic [10:0] n_q, n_d;
    logic [9:0]  o_q, o_d;
    logic [10:0] i_q, i_d;
    logic [10:0] j_q, j_d;
    logic [10:0] k_q, k_d;
    logic        dim_err_q, dim_err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;

    logic        xfer;
    logic [31:0] i_w, j_w, k_w, n_w, o_w, m_w;
    logic [31:0] j_next_w;

    // Byte address of element (row, col) in a row-major word matrix.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] row,
                                              input logic [31:0] stride,
                                              input logic [31:0] col);
        return base + ((row * stride + col) << 2);
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_LD_DIM) || (s == S_LD_A) || (s == S_LD_B) || (s == S_ST_C);
    endfunction

    // An ack only counts while our request is actually outstanding.
    assign xfer     = req_q & mem.mem_ack;
    assign i_w      = {21'd0, i_q};
    assign j_w      = {21'd0, j_q};
    assign k_w      = {21'd0, k_q};
    assign m_w      = {21'd0, m_q};
    assign n_w      = {21'd0, n_q};
    assign o_w      = {22'd0, o_q};
    assign j_next_w = j_w + LANES_W;

    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign dim_err  = dim_err_q;
    assign mem.mem_req  = req_q;
    assign mem.mem_we   = we_q;
    assign mem.mem_addr = addr_q;

    // State, dimension and loop-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            n_q       <= '0;
            o_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            dim_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            o_q       <= o_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            dim_err_q <= dim_err_d;
        end
    end

    // Next-state, loop stepping and strobe outputs.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        o_d       = o_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        dim_err_d = dim_err_q;
        a_ld      = 1'b0;
        b_ld      = 1'b0;
        mac_en    = 1'b0;
        acc_clr   = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LD_DIM;
                    dim_err_d = 1'b0;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                end
            end
            S_LD_DIM: begin
                if (xfer) begin
                    m_d     = mem.mem_rdata[10:0];
                    n_d     = mem.mem_rdata[21:11];
                    o_d     = mem.mem_rdata[31:22];
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if ((m_q == '0) || (n_q == '0) || (o_q == '0)) begin
                    dim_err_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_clr = 1'b1;
                    state_d = S_LD_A;
                end
            end
            S_LD_A: begin
                if (xfer) begin
                    a_ld    = 1'b1;
                    state_d = S_LD_B;
                end
            end
            S_LD_B: begin
                if (xfer) begin
                    b_ld    = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (k_w == n_w - 32'd1) begin
                    k_d     = '0;
                    state_d = S_ST_C;
                end else begin
                    k_d     = k_q + 11'd1;
                    state_d = S_LD_A;
                end
            end
            S_ST_C: begin
                if (xfer) begin
                    acc_clr = 1'b1;
                    if (j_next_w < o_w) begin
                        j_d     = j_next_w[10:0];
                        state_d = S_LD_A;
                    end else begin
                        j_d = '0;
                        if (i_w == m_w - 32'd1) begin
                            state_d = S_FIN;
                        end else begin
                            i_d     = i_q + 11'd1;
                            state_d = S_LD_A;
                        end
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request issue: raise one cycle after entering a memory state, hold
    // until acked, then drop so consecutive requests are always separated.
    always_comb begin
        req_d  = req_q;
        we_d   = we_q;
        addr_d = addr_q;
        if (xfer) begin
            req_d = 1'b0;
        end else if (!req_q && is_mem_state(state_q)) begin
            req_d = 1'b1;
            case (state_q)
                S_LD_DIM: begin
                    we_d   = 1'b0;
                    addr_d = DIM_ADDR;
                end
                S_LD_A: begin
                    we_d   = 1'b0;
                    addr_d = word_addr(A_BASE, i_w, n_w, k_w);
                end
                S_LD_B: begin
                    we_d   = 1'b0;
                    addr_d = word_addr(B_BASE, k_w, o_w, j_w);
                end
                default: begin
                    we_d   = 1'b1;
                    addr_d = word_addr(C_BASE, i_w, o_w, j_w);
                end
            endcase
        end
    end

    // Registered dmem request signals.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            req_q  <= req_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    // Lanes past the right edge of C are masked on the last column block.
    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_mask[l] = busy && ((j_w + 32'(l)) < o_w);
        end
    end

`ifdef MM_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] perf_q, perf_d;

    // Saturating busy-cycle counter, published when the operation finishes.
    always_comb begin
        cnt_d  = cnt_q;
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start) begin
            cnt_d = '0;
        end else if (busy && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (state_q == S_FIN) begin
            perf_d = cnt_q;
        end
    end

    // Counter and published-value registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            perf_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// Testbench for mm_sequencer: a behavioural dmem responder with configurable
// ack latency, a table of dimension vectors with hand-computed request counts
// and store addresses, plus hand-written reset and restart sequences.
module tb_mm_sequencer;

    localparam logic [31:0] DIM_ADDR = 32'h0000_3C00;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        a_ld, b_ld, mac_en, acc_clr, busy, done, dim_err;
    logic [7:0]  lane_mask;
    logic [31:0] perf_cycles;

    mm_sequencer_if mif ();

    mm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem        (mif),
        .a_ld       (a_ld),
        .b_ld       (b_ld),
        .mac_en     (mac_en),
        .acc_clr    (acc_clr),
        .lane_mask  (lane_mask),
        .busy       (busy),
        .done       (done),
        .dim_err    (dim_err),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Responder configuration and observation log.
    logic [31:0] dims_word = '0;
    int          ack_dly   = 0;
    bit          spur      = 1'b0;
    logic [31:0] req_addr [0:63];
    int          n_req, n_store, n_a, n_b, n_mac, n_done, n_busy, n_unstable;
    logic [7:0]  last_mask;
    logic [31:0] last_st_addr;
    logic [31:0] hold_addr;
    logic        hold_we;
    logic        prev_req = 1'b0;
    int          wait_cnt = 0;

    typedef struct {
        logic [31:0] dims;
        int          dly;
        bit          spur;
        int          exp_req;
        int          exp_st;
        int          exp_mac;
        logic        exp_err;
        logic [7:0]  exp_mask;
        logic [31:0] exp_st_addr;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] seq1 [15];
    logic [31:0] seq2 [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: drives ack on the falling edge, then samples outputs 1ns later.
    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            if (mif.mem_req) begin
                if (wait_cnt >= ack_dly) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = (mif.mem_addr == DIM_ADDR) ? dims_word : $urandom;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt    = 0;
                mif.mem_ack = spur;
            end
            #1;
            if (mif.mem_req && !prev_req) begin
                if (n_req < 64) req_addr[n_req] = mif.mem_addr;
                n_req++;
                hold_addr = mif.mem_addr;
                hold_we   = mif.mem_we;
                if (mif.mem_we) begin
                    n_store++;
                    last_mask    = lane_mask;
                    last_st_addr = mif.mem_addr;
                end
            end else if (mif.mem_req && ((mif.mem_addr != hold_addr) || (mif.mem_we != hold_we))) begin
                n_unstable++;
            end
            prev_req = mif.mem_req;
            if (a_ld)   n_a++;
            if (b_ld)   n_b++;
            if (mac_en) n_mac++;
            if (done)   n_done++;
            if (busy)   n_busy++;
        end
    end

    task automatic begin_op(input logic [31:0] dw, input int dly, input bit sp);
        @(negedge clk);
        #3;
        dims_word  = dw;
        ack_dly    = dly;
        spur       = sp;
        n_req      = 0;
        n_store    = 0;
        n_a        = 0;
        n_b        = 0;
        n_mac      = 0;
        n_done     = 0;
        n_busy     = 0;
        n_unstable = 0;
        last_mask    = '0;
        last_st_addr = '0;
        start = 1'b1;
        @(negedge clk);
        #3;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 4000 && n_done == 0; c++) begin
            @(negedge clk);
            #3;
        end
        if (n_done == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done pulse, required one within 4000 cycles", name);
        end
        repeat (3) @(negedge clk);
        #3;
        spur = 1'b0;
    endtask

    task automatic check_perf(input string name);
`ifdef MM_PERF_CNT_EN
        check({name, "_perf"}, perf_cycles, n_busy);
`else
        check({name, "_perf"}, perf_cycles, 32'd0);
`endif
    endtask

    initial begin
        // dims word = m | n<<11 | o<<22
        vecs[0] = '{32'h0200_1802, 0, 1'b0, 15, 2, 6, 1'b0, 8'hFF, 32'h2820}; // 2x3x8
        vecs[1] = '{32'h0280_1001, 0, 1'b0, 11, 2, 4, 1'b0, 8'h03, 32'h2820}; // 1x2x10
        vecs[2] = '{32'h0200_0002, 0, 1'b0,  1, 0, 0, 1'b1, 8'h00, 32'h0000}; // n=0
        vecs[3] = '{32'h0200_1802, 5, 1'b1, 15, 2, 6, 1'b0, 8'hFF, 32'h2820}; // slow acks
        vecs[4] = '{32'h00C0_0801, 0, 1'b0,  4, 1, 1, 1'b0, 8'h07, 32'h2800}; // 1x1x3
        vecs[5] = '{32'h0200_1800, 0, 1'b0,  1, 0, 0, 1'b1, 8'h00, 32'h0000}; // m=0
        vecs[6] = '{32'h0400_0803, 0, 1'b0, 19, 6, 6, 1'b0, 8'hFF, 32'h28A0}; // 3x1x16
        seq1 = '{32'h3C00, 32'h0000, 32'h1400, 32'h0004, 32'h1420, 32'h0008, 32'h1440,
                 32'h2800, 32'h000C, 32'h1400, 32'h0010, 32'h1420, 32'h0014, 32'h1440,
                 32'h2820};
        seq2 = '{32'h3C00, 32'h0000, 32'h1400, 32'h0004, 32'h1428, 32'h2800,
                 32'h0000, 32'h1420, 32'h0004, 32'h1448, 32'h2820};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_req",   {31'd0, mif.mem_req}, 32'd0);
        check("rst_addr",  mif.mem_addr, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_derr",  {31'd0, dim_err}, 32'd0);
        check("rst_mask",  {24'd0, lane_mask}, 32'd0);
        check("rst_perf",  perf_cycles, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            begin_op(vecs[v].dims, vecs[v].dly, vecs[v].spur);
            wait_done(nm);
            check({nm, "_done"},  n_done, 1);
            check({nm, "_reqs"},  n_req, vecs[v].exp_req);
            check({nm, "_st"},    n_store, vecs[v].exp_st);
            check({nm, "_mac"},   n_mac, vecs[v].exp_mac);
            check({nm, "_ald"},   n_a, vecs[v].exp_mac);
            check({nm, "_bld"},   n_b, vecs[v].exp_mac);
            check({nm, "_derr"},  {31'd0, dim_err}, {31'd0, vecs[v].exp_err});
            check({nm, "_stable"}, n_unstable, 0);
            check({nm, "_busy0"}, {31'd0, busy}, 32'd0);
            if (vecs[v].exp_st > 0) begin
                check({nm, "_mask"},  {24'd0, last_mask}, {24'd0, vecs[v].exp_mask});
                check({nm, "_staddr"}, last_st_addr, vecs[v].exp_st_addr);
            end
            check_perf(nm);
            if (v == 0 || v == 3) begin
                for (int r = 0; r < 15; r++) check($sformatf("%s_addr%0d", nm, r), req_addr[r], seq1[r]);
            end
            if (v == 1) begin
                for (int r = 0; r < 11; r++) check($sformatf("%s_addr%0d", nm, r), req_addr[r], seq2[r]);
            end
        end

        // Second start while busy must not restart or extend the operation.
        begin_op(32'h0200_1802, 0, 1'b0);
        repeat (10) @(negedge clk);
        #3;
        start = 1'b1;
        @(negedge clk);
        #3;
        start = 1'b0;
        wait_done("restart");
        check("restart_done", n_done, 1);
        check("restart_reqs", n_req, 15);
        check("restart_st",   n_store, 2);

        // Reset while a B load is outstanding.
        begin_op(32'h0200_1802, 3, 1'b0);
        for (int c = 0; c < 200 && !(mif.mem_req && mif.mem_addr == 32'h1400); c++) begin
            @(negedge clk);
            #3;
        end
        check("rstmid_inldb", {31'd0, mif.mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #3;
        check("rstmid_req",  {31'd0, mif.mem_req}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_addr", mif.mem_addr, 32'd0);
        reset = 1'b0;
        begin_op(32'h0200_1802, 0, 1'b0);
        wait_done("rerun");
        check("rerun_done", n_done, 1);
        check("rerun_reqs", n_req, 15);
        for (int r = 0; r < 15; r++) check($sformatf("rerun_addr%0d", r), req_addr[r], seq1[r]);
        check_perf("rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
